// File: rtl/router_pkt_pkg.sv
// Packet format shared by the transmit encoder and the receive decoder:
// magic words, header field positions, beat indices and controller states.
package router_pkt_pkg;

  localparam logic [15:0] HDR_MAGIC  = 16'hA5C3;
  localparam logic [15:0] TAIL_MAGIC = 16'h5A3C;

  localparam int MAGIC_LSB = 48;
  localparam int MAGIC_W   = 16;
  localparam int SEQ_LSB   = 40;
  localparam int SEQ_W     = 8;
  localparam int LEN_LSB   = 32;
  localparam int LEN_W     = 8;
  localparam int ADDR_LSB  = 0;
  localparam int ADDR_W    = 32;

  localparam int HDR_BEAT           = 0;
  localparam int FIRST_PAYLOAD_BEAT = 1;

  // Beat indices past the header depend on the payload beat count p.
  function automatic int last_payload_beat(input int p);
    return p;
  endfunction

  function automatic int csum_beat(input int p);
    return p + 1;
  endfunction

  function automatic int tail_beat(input int p);
    return p + 2;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_LOAD = 2'd2,
    ST_SEND = 2'd3
  } tx_state_t;

endpackage

// File: rtl/router_pkt_encoder.sv
// Holds the word being sent, accumulates the payload XOR checksum and
// selects the beat presented to the packet FIFO.
module router_pkt_encoder
  import router_pkt_pkg::*;
#(
  parameter int DATA_WIDTH        = 1024,
  parameter int ADDR_WIDTH        = 10,
  parameter int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
  parameter int AURORA_DATA_WIDTH = 64,
  parameter int NUMBER_PACKET     = 19,
  parameter int BEAT_W            = $clog2(NUMBER_PACKET)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load,
  input  logic                         send,
  input  logic                         write,
  input  logic [BEAT_W-1:0]            beat,
  input  logic [7:0]                   seq,
  input  logic [DATA_DFX_WIDTH-1:0]    word,
  output logic [AURORA_DATA_WIDTH-1:0] beat_data
);

  localparam int P  = DATA_WIDTH / AURORA_DATA_WIDTH;
  localparam int PW = (P > 1) ? $clog2(P) : 1;

  localparam logic [BEAT_W-1:0] HDR_IDX   = BEAT_W'(HDR_BEAT);
  localparam logic [BEAT_W-1:0] FIRST_IDX = BEAT_W'(FIRST_PAYLOAD_BEAT);
  localparam logic [BEAT_W-1:0] LAST_IDX  = BEAT_W'(last_payload_beat(P));
  localparam logic [BEAT_W-1:0] CSUM_IDX  = BEAT_W'(csum_beat(P));
  localparam logic [BEAT_W-1:0] TAIL_IDX  = BEAT_W'(tail_beat(P));

  logic [ADDR_WIDTH-1:0]               addr_q;
  logic [P-1:0][AURORA_DATA_WIDTH-1:0] data_q;
  logic [AURORA_DATA_WIDTH-1:0]        csum_q;
  logic [AURORA_DATA_WIDTH-1:0]        chunk;
  logic [AURORA_DATA_WIDTH-1:0]        hdr;
  logic [AURORA_DATA_WIDTH-1:0]        tail;
  logic [PW-1:0]                       pidx;
  logic                                is_payload;

  assign pidx       = PW'(beat - FIRST_IDX);
  assign chunk      = data_q[pidx];
  assign is_payload = (beat >= FIRST_IDX) && (beat <= LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      data_q <= '0;
      csum_q <= '0;
    end else if (load) begin
      addr_q <= word[DATA_DFX_WIDTH-1:DATA_WIDTH];
      data_q <= word[DATA_WIDTH-1:0];
      csum_q <= '0;
    end else if (write && is_payload) begin
      csum_q <= csum_q ^ chunk;
    end
  end

  always_comb begin
    hdr = '0;
    hdr[MAGIC_LSB +: MAGIC_W] = HDR_MAGIC;
    hdr[SEQ_LSB +: SEQ_W]     = seq;
    hdr[LEN_LSB +: LEN_W]     = LEN_W'(NUMBER_PACKET);
    hdr[ADDR_LSB +: ADDR_W]   = ADDR_W'(addr_q);
    tail = '0;
    tail[MAGIC_LSB +: MAGIC_W] = TAIL_MAGIC;
    tail[SEQ_LSB +: SEQ_W]     = seq;
  end

  always_comb begin
    beat_data = '0;
    if (send) begin
      if (beat == HDR_IDX)       beat_data = hdr;
      else if (is_payload)       beat_data = chunk;
      else if (beat == CSUM_IDX) beat_data = csum_q;
      else if (beat == TAIL_IDX) beat_data = tail;
    end
  end

endmodule

// File: rtl/router_controller_send.sv
// Transmit router controller: wins the arbiter, pops one word and streams
// it as a fixed-length packet into the Aurora TX packet FIFO.
//
// state | meaning
// IDLE  | waiting for a word in the arbiter FIFO
// REQ   | requesting the arbiter; pop on grant
// LOAD  | popped word valid, capture into the encoder
// SEND  | writing beats, stalled while the packet FIFO is full
module router_controller_send
  import router_pkt_pkg::*;
#(
  parameter int DATA_WIDTH        = 1024,
  parameter int ADDR_WIDTH        = 10,
  parameter int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
  parameter int AURORA_DATA_WIDTH = 64,
  parameter int NUMBER_PACKET     = 19
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         empty_arbiter_fifo,
  output logic                         read_arbiter_fifo,
  input  logic [DATA_DFX_WIDTH-1:0]    data_arbiter_fifo,
  output logic                         arbiter_read_req,
  input  logic                         arbiter_read_gnt,
  input  logic                         full_pkt_fifo,
  output logic                         write_pkt_fifo,
  output logic [AURORA_DATA_WIDTH-1:0] data_pkt_fifo,
  output logic                         busy,
  output logic                         tx_done
);

  localparam int                BEAT_W    = $clog2(NUMBER_PACKET);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUMBER_PACKET - 1);

  tx_state_t         state_q, state_d;
  logic [BEAT_W-1:0] beat_q;
  logic [7:0]        seq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_LOAD || tx_done) beat_q <= '0;
      else if (write_pkt_fifo)           beat_q <= beat_q + 1'b1;
      if (tx_done) seq_q <= seq_q + 8'd1;
    end
  end

  always_comb begin
    state_d           = state_q;
    arbiter_read_req  = 1'b0;
    read_arbiter_fifo = 1'b0;
    write_pkt_fifo    = 1'b0;
    tx_done           = 1'b0;
    unique case (state_q)
      ST_IDLE: if (!empty_arbiter_fifo) state_d = ST_REQ;
      ST_REQ: begin
        arbiter_read_req = 1'b1;
        if (arbiter_read_gnt) begin
          read_arbiter_fifo = 1'b1;
          state_d           = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: begin
        write_pkt_fifo = !full_pkt_fifo;
        if (!full_pkt_fifo && beat_q == LAST_BEAT) begin
          tx_done = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  router_pkt_encoder #(
    .DATA_WIDTH        (DATA_WIDTH),
    .ADDR_WIDTH        (ADDR_WIDTH),
    .DATA_DFX_WIDTH    (DATA_DFX_WIDTH),
    .AURORA_DATA_WIDTH (AURORA_DATA_WIDTH),
    .NUMBER_PACKET     (NUMBER_PACKET),
    .BEAT_W            (BEAT_W)
  ) u_encoder (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (state_q == ST_LOAD),
    .send      (state_q == ST_SEND),
    .write     (write_pkt_fifo),
    .beat      (beat_q),
    .seq       (seq_q),
    .word      (data_arbiter_fifo),
    .beat_data (data_pkt_fifo)
  );

endmodule

// File: tb/tb_router_controller_send.sv
// Directed bench for router_controller_send: table of single-packet cases
// plus sequences for seq wrap / throughput and mid-packet reset.
module tb_router_controller_send;

  localparam int NP = 19;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          empty_arbiter_fifo;
  logic          read_arbiter_fifo;
  logic [1033:0] data_arbiter_fifo;
  logic          arbiter_read_req;
  logic          arbiter_read_gnt;
  logic          full_pkt_fifo;
  logic          write_pkt_fifo;
  logic [63:0]   data_pkt_fifo;
  logic          busy;
  logic          tx_done;

  router_controller_send dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .empty_arbiter_fifo (empty_arbiter_fifo),
    .read_arbiter_fifo  (read_arbiter_fifo),
    .data_arbiter_fifo  (data_arbiter_fifo),
    .arbiter_read_req   (arbiter_read_req),
    .arbiter_read_gnt   (arbiter_read_gnt),
    .full_pkt_fifo      (full_pkt_fifo),
    .write_pkt_fifo     (write_pkt_fifo),
    .data_pkt_fifo      (data_pkt_fifo),
    .busy               (busy),
    .tx_done            (tx_done)
  );

  always #5 clk = ~clk;

  // stimulus configuration read by the grant / back-pressure drivers
  int gnt_delay  = 0;
  bit gnt_idle   = 1'b0;
  int stall_beat = 0;
  int stall_len  = 0;

  // monitor state (written only by the monitor)
  int          mon_cyc = 0, mon_reads = 0, mon_writes = 0, mon_reqs = 0, mon_dones = 0;
  int          mon_bad_wr = 0, mon_read_cyc = 0, mon_first_cyc = 0, mon_done_cyc = 0;
  int          pk_wr = 0, stall_seen = 0, stall_unstable = 0;
  logic [63:0] stall_prev;
  logic [63:0] cap [0:NP-1];
  logic [63:0] hdr_q [$];
  int          done_q [$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (arbiter_read_req) mon_reqs++;
      if (read_arbiter_fifo) begin
        mon_reads++;
        mon_read_cyc   = mon_cyc;
        pk_wr          = 0;
        stall_seen     = 0;
        stall_unstable = 0;
      end
      if (write_pkt_fifo) begin
        if (full_pkt_fifo) mon_bad_wr++;
        if (pk_wr < NP) cap[pk_wr] = data_pkt_fifo;
        if (pk_wr == 0) begin
          mon_first_cyc = mon_cyc;
          hdr_q.push_back(data_pkt_fifo);
        end
        pk_wr++;
        mon_writes++;
      end
      if (full_pkt_fifo && busy && !arbiter_read_req) begin
        if (stall_seen > 0 && data_pkt_fifo !== stall_prev) stall_unstable++;
        stall_prev = data_pkt_fifo;
        stall_seen++;
      end
      if (tx_done) begin
        mon_dones++;
        mon_done_cyc = mon_cyc;
        done_q.push_back(mon_cyc);
      end
    end
    mon_cyc++;
  end

  int req_run = 0;
  initial begin
    arbiter_read_gnt = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && arbiter_read_req) begin
        arbiter_read_gnt = (req_run >= gnt_delay);
        req_run++;
      end else begin
        arbiter_read_gnt = gnt_idle;
        req_run = 0;
      end
    end
  end

  int stall_left = 0;
  initial begin
    full_pkt_fifo = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (arbiter_read_req) stall_left = stall_len;
      if (stall_left > 0 && busy && !arbiter_read_req && pk_wr == stall_beat) begin
        full_pkt_fifo = 1'b1;
        stall_left--;
      end else begin
        full_pkt_fifo = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int pass_cnt = 0, total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [1023:0] make_word(input int pat);
    logic [1023:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      case (pat)
        0:       w[i*64 +: 64] = 64'(i);
        1:       w[i*64 +: 64] = (i == 0) ? 64'h1 : {64{1'b1}};
        default: w[i*64 +: 64] = 64'h1 << i;
      endcase
    end
    return w;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [9:0]  addr;
    int          pattern;
    int          gnt_delay;
    bit          gnt_idle;
    int          stall_beat;
    int          stall_len;
    logic [63:0] exp_hdr;
    logic [63:0] exp_csum;
    logic [63:0] exp_tail;
    int          exp_done_ofs;
  } vec_t;

  vec_t vecs [3];

  initial begin
    logic [1023:0] word;
    int r0, w0, q0, d0, g, perr, serr, terr, hb, db;
    logic [63:0] h;

    vecs[0] = '{10'h2A5, 0, 0, 1'b0, 0, 0, 64'hA5C3_0013_0000_02A5,
                64'h0, 64'h5A3C_0000_0000_0000, 20};
    vecs[1] = '{10'h3FF, 1, 5, 1'b1, 0, 0, 64'hA5C3_0113_0000_03FF,
                64'hFFFF_FFFF_FFFF_FFFE, 64'h5A3C_0100_0000_0000, 20};
    vecs[2] = '{10'h001, 2, 2, 1'b0, 7, 4, 64'hA5C3_0213_0000_0001,
                64'h0000_0000_0000_FFFF, 64'h5A3C_0200_0000_0000, 24};

    rst_n = 1'b0;
    empty_arbiter_fifo = 1'b1;
    data_arbiter_fifo  = '0;
    #1;
    check("reset_outputs",
          64'({read_arbiter_fifo, arbiter_read_req, write_pkt_fifo, busy, tx_done, |data_pkt_fifo}),
          64'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int v = 0; v < 3; v++) begin
      word       = make_word(vecs[v].pattern);
      gnt_delay  = vecs[v].gnt_delay;
      gnt_idle   = vecs[v].gnt_idle;
      stall_beat = vecs[v].stall_beat;
      stall_len  = vecs[v].stall_len;
      data_arbiter_fifo = {vecs[v].addr, word};
      r0 = mon_reads; w0 = mon_writes; q0 = mon_reqs; d0 = mon_dones;
      @(posedge clk); #1;
      empty_arbiter_fifo = 1'b0;
      g = 0;
      while (mon_reads == r0 && g < 50) begin @(posedge clk); #1; g++; end
      empty_arbiter_fifo = 1'b1;
      g = 0;
      while (mon_dones == d0 && g < 100) begin @(posedge clk); #1; g++; end
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("v%0d_done_seen", v), 64'(mon_dones - d0), 64'd1);
      check($sformatf("v%0d_reads", v), 64'(mon_reads - r0), 64'd1);
      check($sformatf("v%0d_writes", v), 64'(mon_writes - w0), 64'(NP));
      check($sformatf("v%0d_req_cycles", v), 64'(mon_reqs - q0), 64'(vecs[v].gnt_delay + 1));
      check($sformatf("v%0d_first_beat_lat", v), 64'(mon_first_cyc - mon_read_cyc), 64'd2);
      check($sformatf("v%0d_done_lat", v), 64'(mon_done_cyc - mon_read_cyc), 64'(vecs[v].exp_done_ofs));
      check($sformatf("v%0d_header", v), cap[0], vecs[v].exp_hdr);
      perr = 0;
      for (int k = 1; k <= 16; k++) if (cap[k] !== word[(k-1)*64 +: 64]) perr++;
      check($sformatf("v%0d_payload_errs", v), 64'(perr), 64'd0);
      check($sformatf("v%0d_checksum", v), cap[17], vecs[v].exp_csum);
      check($sformatf("v%0d_tail", v), cap[18], vecs[v].exp_tail);
      check($sformatf("v%0d_writes_while_full", v), 64'(mon_bad_wr), 64'd0);
      check($sformatf("v%0d_stall_cycles", v), 64'(stall_seen), 64'(vecs[v].stall_len));
      if (vecs[v].stall_len > 0) begin
        check($sformatf("v%0d_stall_unstable", v), 64'(stall_unstable), 64'd0);
        check($sformatf("v%0d_stall_data", v), stall_prev, 64'h40);
      end
      if (vecs[v].pattern == 1) check($sformatf("v%0d_beat1", v), cap[1], 64'h1);
    end

    // 257 back-to-back packets: seq wrap and 22-cycle period
    do_reset();
    gnt_delay = 0; gnt_idle = 1'b0; stall_len = 0; stall_beat = 0;
    data_arbiter_fifo = {10'h155, make_word(0)};
    hb = hdr_q.size(); db = done_q.size();
    r0 = mon_reads; w0 = mon_writes; d0 = mon_dones;
    empty_arbiter_fifo = 1'b0;
    g = 0;
    while (mon_dones < d0 + 257 && g < 257 * 22 + 200) begin @(posedge clk); #1; g++; end
    empty_arbiter_fifo = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("b2b_dones", 64'(mon_dones - d0), 64'd257);
    check("b2b_reads", 64'(mon_reads - r0), 64'd257);
    check("b2b_writes", 64'(mon_writes - w0), 64'(257 * NP));
    serr = 0; terr = 0;
    if (hdr_q.size() >= hb + 257 && done_q.size() >= db + 257) begin
      for (int i = 0; i < 257; i++) begin
        h = hdr_q[hb + i];
        if (h[47:40] !== 8'(i % 256)) serr++;
        if (i > 0 && done_q[db + i] - done_q[db + i - 1] != 22) terr++;
      end
      h = hdr_q[hb + 256];
    end else begin
      serr = -1; terr = -1; h = '1;
    end
    check("b2b_seq_errs", 64'(serr), 64'd0);
    check("b2b_period_errs", 64'(terr), 64'd0);
    check("b2b_seq_wrap", 64'(h[47:40]), 64'd0);

    // reset during beat 10 of the second packet
    do_reset();
    d0 = mon_dones;
    empty_arbiter_fifo = 1'b0;
    g = 0;
    while (mon_dones == d0 && g < 100) begin @(posedge clk); #1; g++; end
    g = 0;
    while (!(busy && !arbiter_read_req && pk_wr == 10) && g < 100) begin @(posedge clk); #1; g++; end
    check("rst_reached_beat10", 64'(pk_wr), 64'd10);
    rst_n = 1'b0;
    #1;
    check("rst_outputs_zero",
          64'({read_arbiter_fifo, arbiter_read_req, write_pkt_fifo, busy, tx_done, |data_pkt_fifo}),
          64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_no_partial_done", 64'(mon_dones - d0), 64'd1);
    hb = hdr_q.size(); d0 = mon_dones;
    g = 0;
    while (hdr_q.size() == hb && g < 50) begin @(posedge clk); #1; g++; end
    empty_arbiter_fifo = 1'b1;
    if (hdr_q.size() > hb) h = hdr_q[hb];
    else h = '1;
    check("rst_next_seq", 64'(h[47:40]), 64'd0);
    g = 0;
    while (mon_dones == d0 && g < 100) begin @(posedge clk); #1; g++; end
    check("rst_next_done", 64'(mon_dones - d0), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
